// File: rtl/receiver_if.sv
// Serial receiver bus bundle: line input, oversample tick, read strobe and byte/flag outputs.
// Latency: none, wiring only.
// Backpressure: none; the host acknowledges a held byte with rda_clr.
interface receiver_if;
  logic       RxD;
  logic       rxEnable;
  logic       rda_clr;
  logic [7:0] rx_data;
  logic       RDA;
  logic       FE;
  logic       OE;

  // Receiver side.
  modport slave (
    input  RxD, rxEnable, rda_clr,
    output rx_data, RDA, FE, OE
  );

  // Bus / host side.
  modport master (
    output RxD, rxEnable, rda_clr,
    input  rx_data, RDA, FE, OE
  );
endinterface

// File: rtl/receiver.sv
// 8N1 UART receiver that oversamples RxD on rxEnable ticks and holds the last byte with RDA/FE/OE flags.
// Latency: RDA rises on the stop-bit sample tick, OVERSAMPLE/2 + 9*OVERSAMPLE ticks after start detect.
// Backpressure: none; an unread byte is overwritten and flagged by OE, and rda_clr acknowledges it.
module receiver #(
  parameter int OVERSAMPLE = 16   // even, >= 4
) (
  input  logic      clk,
  input  logic      rst,
  receiver_if.slave bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] HALF_M1 = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rxs_q;
  logic [CW-1:0]   tick_cnt_q, tick_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rda_q, rda_d;
  logic            fe_q, fe_d;
  logic            oe_q, oe_d;

  logic            half_done, full_done;
  logic            cnt_clr, bit_clr, bit_sample, byte_done;

  assign half_done = (tick_cnt_q == HALF_M1);
  assign full_done = (tick_cnt_q == FULL_M1);

  // Two-flop synchronizer on the asynchronous serial line; resets to the idle level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      rxs_q   <= 1'b1;
    end else begin
      sync1_q <= bus.RxD;
      rxs_q   <= sync1_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic; only oversample ticks move the machine.
  always_comb begin
    state_d = state_q;
    if (bus.rxEnable) begin
      unique case (state_q)
        IDLE:      if (!rxs_q) state_d = START;
        // Mid start bit: a line back high means the low level was a glitch.
        START:     if (half_done) state_d = rxs_q ? IDLE : DATA;
        DATA:      if (full_done && (bit_idx_q == 3'd7)) state_d = STOP;
        // A low stop bit may be a break; wait for the line to recover before hunting again.
        STOP:      if (full_done) state_d = rxs_q ? IDLE : WAIT_HIGH;
        WAIT_HIGH: if (rxs_q) state_d = IDLE;
        default:   state_d = IDLE;
      endcase
    end
  end

  // FSM output decode: counter control and sample/complete strobes.
  always_comb begin
    cnt_clr    = 1'b0;
    bit_clr    = 1'b0;
    bit_sample = 1'b0;
    byte_done  = 1'b0;
    if (bus.rxEnable) begin
      unique case (state_q)
        IDLE:      cnt_clr = 1'b1;
        START: begin
          cnt_clr = half_done;
          bit_clr = half_done;
        end
        DATA: begin
          cnt_clr    = full_done;
          bit_sample = full_done;
        end
        STOP: begin
          cnt_clr   = full_done;
          byte_done = full_done;
        end
        WAIT_HIGH: cnt_clr = 1'b1;
        default:   cnt_clr = 1'b1;
      endcase
    end
  end

  // Datapath next state: tick/bit counters, shift register and host-visible flags.
  always_comb begin
    tick_cnt_d = tick_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rda_d      = rda_q;
    fe_d       = fe_q;
    oe_d       = oe_q;

    if (bus.rxEnable) tick_cnt_d = cnt_clr ? '0 : tick_cnt_q + 1'b1;

    if (bit_clr) begin
      bit_idx_d = 3'd0;
    end else if (bit_sample) begin
      shift_d[bit_idx_q] = rxs_q;
      bit_idx_d          = bit_idx_q + 3'd1;
    end

    // A completing byte beats a simultaneous read strobe: the new byte stays
    // flagged as available, and the strobe still counts as reading the old one.
    if (byte_done) begin
      rx_data_d = shift_q;
      rda_d     = 1'b1;
      fe_d      = ~rxs_q;
      oe_d      = (rda_q && !bus.rda_clr) ? 1'b1 : (bus.rda_clr ? 1'b0 : oe_q);
    end else if (bus.rda_clr) begin
      rda_d = 1'b0;
      oe_d  = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      shift_q    <= 8'h00;
      rx_data_q  <= 8'h00;
      rda_q      <= 1'b0;
      fe_q       <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rda_q      <= rda_d;
      fe_q       <= fe_d;
      oe_q       <= oe_d;
    end
  end

  assign bus.rx_data = rx_data_q;
  assign bus.RDA     = rda_q;
  assign bus.FE      = fe_q;
  assign bus.OE      = oe_q;

endmodule

// File: tb/tb_receiver.sv
// Directed and randomized frames against a byte-level model of the receiver's host-visible state.
// Latency: RDA expected DONE_K clocks after the start bit is driven (sync + detect + 152 ticks).
// Backpressure: rda_clr exercised before, coincident with, and absent around byte completion.
module tb_receiver;

  localparam int OS         = 16;
  localparam int DETECT_LAG = 3;                         // two synchronizer flops + detect tick
  localparam int DONE_K     = DETECT_LAG + OS/2 + 9*OS;  // clock index of byte completion
  localparam int FRAME_CYC  = 10 * OS;

  logic clk = 1'b0;
  logic rst = 1'b0;

  receiver_if bus();

  receiver #(.OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Records the cycle on which RDA was last seen rising.
  int   rise_cyc = -1;
  logic rda_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.RDA && !rda_prev) rise_cyc <= cyc;
    rda_prev <= bus.RDA;
  end

  // Reference model: what the host should see after each frame.
  logic [7:0] m_data;
  logic       m_rda, m_fe, m_oe;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".rx_data"}, 32'(bus.rx_data), 32'(m_data));
    chk({tag, ".RDA"},     32'(bus.RDA),     32'(m_rda));
    chk({tag, ".FE"},      32'(bus.FE),      32'(m_fe));
    chk({tag, ".OE"},      32'(bus.OE),      32'(m_oe));
  endtask

  // Drives the first ncyc clocks of a frame; rda_clr pulses on clock clr_k (-1 for none).
  task automatic send_bits(input logic [7:0] b, input logic stopb, input int clr_k, input int ncyc);
    logic [9:0] fr;
    fr = {stopb, b, 1'b0};
    for (int k = 0; k < ncyc; k++) begin
      bus.RxD     = fr[k / OS];
      bus.rda_clr = (k == clr_k);
      @(posedge clk); #1;
    end
    bus.rda_clr = 1'b0;
  endtask

  // Whole frame plus model update.
  task automatic frame(input logic [7:0] b, input logic stopb, input logic coinc);
    send_bits(b, stopb, coinc ? DONE_K - 1 : -1, FRAME_CYC);
    if (coinc)      m_oe = 1'b0;
    else if (m_rda) m_oe = 1'b1;
    m_rda  = 1'b1;
    m_data = b;
    m_fe   = ~stopb;
  endtask

  task automatic idle(input int n);
    bus.RxD = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic clr_pulse();
    bus.rda_clr = 1'b1;
    @(posedge clk); #1;
    bus.rda_clr = 1'b0;
    m_rda = 1'b0;
    m_oe  = 1'b0;
  endtask

  initial begin
    int         start_cyc;
    logic [7:0] b;
    logic       stopb;
    int         mode;

    bus.RxD      = 1'b1;
    bus.rxEnable = 1'b1;
    bus.rda_clr  = 1'b0;
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;

    // Reset values.
    #1 rst = 1'b1;
    #1 check_all("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(10);
    check_all("post_reset");

    // Good frame 0xA5 with exact completion latency.
    start_cyc = cyc;
    frame(8'hA5, 1'b1, 1'b0);
    chk("a5.latency", 32'(rise_cyc - start_cyc), 32'(DONE_K));
    chk("a5.byte", 32'(bus.rx_data), 32'hA5);
    check_all("a5");
    idle(8);

    // Short low glitch in idle is rejected.
    clr_pulse();
    check_all("clr_after_a5");
    bus.RxD = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    idle(3 * OS);
    check_all("glitch");

    // Framing error followed by a long break: exactly one byte.
    frame(8'h3C, 1'b0, 1'b0);
    check_all("fe_frame");
    bus.RxD = 1'b0;
    repeat (40 * OS) begin @(posedge clk); #1; end
    check_all("break");
    idle(3 * OS);
    clr_pulse();
    frame(8'h01, 1'b1, 1'b0);
    check_all("after_break");
    chk("after_break.fe0", 32'(bus.FE), 32'h0);
    idle(8);

    // Overrun: two bytes without an acknowledge.
    clr_pulse();
    frame(8'h11, 1'b1, 1'b0);
    idle(5);
    frame(8'h22, 1'b1, 1'b0);
    check_all("overrun");
    chk("overrun.oe1", 32'(bus.OE), 32'h1);
    clr_pulse();
    check_all("overrun_clr");
    idle(5);

    // Acknowledge coincident with completion while RDA is held.
    frame(8'h33, 1'b1, 1'b0);
    idle(5);
    frame(8'h55, 1'b1, 1'b1);
    check_all("coincident");
    chk("coincident.oe0", 32'(bus.OE), 32'h0);
    idle(5);

    // Reset in the middle of data bit 4 abandons the frame.
    send_bits(8'h6E, 1'b1, -1, 5 * OS + 8);
    rst = 1'b1;
    bus.RxD = 1'b1;
    #1;
    m_data = 8'h00; m_rda = 1'b0; m_fe = 1'b0; m_oe = 1'b0;
    check_all("rst_mid");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(12 * OS);
    check_all("rst_idle");
    frame(8'h81, 1'b1, 1'b0);
    check_all("rst_81");
    idle(6);

    // Randomized frames, stop bits and acknowledge placement.
    for (int i = 0; i < 24; i++) begin
      b     = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      mode  = int'($urandom_range(0, 2));
      if (mode == 1) clr_pulse();
      frame(b, stopb, mode == 2);
      check_all($sformatf("rand%0d", i));
      idle(int'($urandom_range(4, 20)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/receiver.md
RECEIVER -- requirements
Module: receiver

Interface
REQ-001 Parameter: OVERSAMPLE, 16, rxEnable ticks per bit period; must be even and at least 4.
REQ-002 Port: clk  input  1  system clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: RxD  input  1  serial line; idle high; 8N1 frame format; data sent LSB first.
REQ-005 Port: rxEnable  input  1  single-cycle oversample tick at OVERSAMPLE x baud, from the baud generator.
REQ-006 Port: rda_clr  input  1  single-cycle read strobe from the bus interface; acknowledges the held byte.
REQ-007 Port: rx_data  output  8  last received byte; stable while RDA=1.
REQ-008 Port: RDA  output  1  receive data available.
REQ-009 Port: FE  output  1  framing error on the last byte (stop bit sampled 0).
REQ-010 Port: OE  output  1  overrun; a byte completed while RDA was already 1.

Function
REQ-011 RxD SHALL pass through a two-flop synchronizer (reset value 1); all decisions use the synchronized value rxs.
REQ-012 States SHALL be IDLE, START, DATA, STOP and WAIT_HIGH; the FSM, tick counter and bit counter SHALL advance only on cycles with rxEnable=1.
REQ-013 IDLE: rxs=0 on a tick -> START, tick counter cleared; otherwise remain in IDLE.
REQ-014 START: on tick OVERSAMPLE/2-1 after entry, rxs=0 -> DATA (tick counter and bit index cleared); rxs=1 -> IDLE (glitch rejected, no flag change).
REQ-015 DATA: every OVERSAMPLE ticks, sample rxs into shift[bit index], LSB first; after bit 7 is sampled -> STOP.
REQ-016 STOP: OVERSAMPLE ticks after the bit-7 sample, sample rxs; on the same clock edge load rx_data from shift and set RDA=1.
REQ-017 STOP with rxs=1 -> FE=0 and next state IDLE; STOP with rxs=0 -> FE=1 and next state WAIT_HIGH.
REQ-018 WAIT_HIGH: remain until a tick with rxs=1, then -> IDLE; a line held low (break) SHALL yield exactly one byte.
REQ-019 Byte completion with RDA=1 and no rda_clr in the same cycle -> OE=1 and rx_data overwritten.
REQ-020 rda_clr SHALL clear RDA and OE on the next edge; FE SHALL hold until the next byte completes.
REQ-021 rda_clr in the same cycle as byte completion: the new byte wins, RDA=1, OE not set.
REQ-022 Latency: RDA rises on the clock edge of the stop-bit sample tick, which is ((OVERSAMPLE/2) + 9*OVERSAMPLE) ticks after the start tick in IDLE.
REQ-023 rda_clr has no effect on the FSM; a reception in progress continues regardless of rda_clr.

Reset
REQ-024 rst SHALL force state=IDLE, counters=0, shift=0, synchronizer=1, rx_data=8'h00, RDA=0, FE=0, OE=0.
REQ-025 rst asserted mid-frame SHALL abandon the frame; after release, no byte is delivered until a fresh start bit is seen.

Verification
REQ-026 rxEnable=1 every cycle; drive frame 0xA5 (16 clk/bit) -> rx_data=8'hA5, RDA=1, FE=0, OE=0 at 152 ticks after the start detect.
REQ-027 Low pulse of 4 clk in idle -> returns to IDLE, RDA stays 0, no flags change.
REQ-028 Frame 0x3C with stop bit 0, then line held low 40 bit times -> rx_data=8'h3C, RDA=1, FE=1, exactly one byte; next good frame 0x01 -> FE=0.
REQ-029 Two frames 0x11 then 0x22 without rda_clr -> rx_data=8'h22, OE=1; rda_clr pulse -> RDA=0, OE=0.
REQ-030 rda_clr coincident with completion of 0x55 while RDA=1 -> RDA=1, OE=0, rx_data=8'h55.
REQ-031 rst pulsed during bit 4 of a frame -> all outputs 0; following frame 0x81 received correctly.
